vram_arbiter: RTL

//  Shares one single-port synchronous framebuffer RAM between two users:
//   - the video scan-out path, driven by the 640x480 VGA timing generator;
//   - the RISC-V CPU load/store port.

---
 rtl/vram_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: video scan-out reads take absolute priority,
// the CPU load/store port is served on every other cycle via req/ack.
module vram_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int SCALE  = 4,
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_ack,
  output logic [PIX_W-1:0]  cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              video_out
);

  localparam int                SH      = $clog2(SCALE);
  localparam logic [9:0]        X_MASK  = 10'(SCALE - 1);
  localparam logic [9:0]        FB_W_X  = 10'(FB_W);
  localparam logic [9:0]        FB_H_Y  = 10'(FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);
  localparam logic [ADDR_W:0]   FB_SZ   = (ADDR_W + 1)'(FB_W * FB_H);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t             state_q, state_d;
  logic               ack_rd_q, ack_rd_d;
  logic               grant;

  logic [9:0]         xs, ys;
  logic               in_fb, vslot, cpu_in_range;
  logic [ADDR_W-1:0]  vaddr;

  logic               vrd_p1_q, vrd_p1_d;
  logic               border_p1_q, border_p1_d;
  logic               von_p1_q, von_p1_d;
  logic               hs_p1_q, hs_p1_d;
  logic               vs_p1_q, vs_p1_d;
  logic [PIX_W-1:0]   pix_p2_q, pix_p2_d;
  logic               von_p2_q, von_p2_d;
  logic               hs_p2_q, hs_p2_d;
  logic               vs_p2_q, vs_p2_d;

  // Scaled framebuffer coordinates; SCALE is a power of two so division is a shift.
  assign xs           = x >> SH;
  assign ys           = y >> SH;
  assign in_fb        = (xs < FB_W_X) && (ys < FB_H_Y);
  assign vslot        = video_on && ((x & X_MASK) == 10'd0) && in_fb;
  assign vaddr        = ADDR_W'(ys) * FB_W_A + ADDR_W'(xs);
  assign cpu_in_range = {1'b0, cpu_addr} < FB_SZ;

  always_comb begin
    state_d  = state_q;
    ack_rd_d = ack_rd_q;
    grant    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req && !vslot) begin
          grant    = 1'b1;
          state_d  = S_ACK;
          ack_rd_d = !cpu_we && cpu_in_range;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port mux: video slot wins, an out-of-range CPU grant leaves the port idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!reset) begin
      if (vslot) begin
        ram_en   = 1'b1;
        ram_addr = vaddr;
      end else if (grant && cpu_in_range) begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
    end
  end

  assign cpu_ack   = (state_q == S_ACK) && !reset;
  assign cpu_rdata = (cpu_ack && ack_rd_q) ? ram_rdata : '0;

  // Stage p1: fetch issued, RAM data arrives this stage.
  always_comb begin
    vrd_p1_d    = vslot;
    border_p1_d = video_on && !in_fb;
    von_p1_d    = video_on;
    hs_p1_d     = hsync_in;
    vs_p1_d     = vsync_in;
  end

  // Stage p2: pixel captured and held for SCALE columns; border forces black.
  always_comb begin
    pix_p2_d = pix_p2_q;
    if (vrd_p1_q)         pix_p2_d = ram_rdata;
    else if (border_p1_q) pix_p2_d = '0;
    von_p2_d = von_p1_q;
    hs_p2_d  = hs_p1_q;
    vs_p2_d  = vs_p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ack_rd_q    <= 1'b0;
      vrd_p1_q    <= 1'b0;
      border_p1_q <= 1'b0;
      von_p1_q    <= 1'b0;
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
      pix_p2_q    <= '0;
      von_p2_q    <= 1'b0;
      hs_p2_q     <= 1'b1;
      vs_p2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      ack_rd_q    <= ack_rd_d;
      vrd_p1_q    <= vrd_p1_d;
      border_p1_q <= border_p1_d;
      von_p1_q    <= von_p1_d;
      hs_p1_q     <= hs_p1_d;
      vs_p1_q     <= vs_p1_d;
      pix_p2_q    <= pix_p2_d;
      von_p2_q    <= von_p2_d;
      hs_p2_q     <= hs_p2_d;
      vs_p2_q     <= vs_p2_d;
    end
  end

  assign rgb       = von_p2_q ? pix_p2_q : '0;
  assign hsync     = hs_p2_q;
  assign vsync     = vs_p2_q;
  assign video_out = von_p2_q;

endmodule
